// File: rtl/vblank_dma_pkg.sv
// Shared types and constants for the vblank copy engine.
package vblank_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // Address map regions commonly used as source / destination.
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] TB_BASE  = 16'hF000;
  localparam logic [15:0] SPR_BASE = 16'hEFF0;

  // Bus direction encoding for rw.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/vblank_dma_trigger.sv
// Trigger qualification for the copy engine: vsync rising-edge detect,
// start/vsync merge, and a latch remembering which source launched the
// current transfer (only vsync-launched transfers may be aborted by vsync).
module vblank_dma_trigger #(
  parameter int AUTO_VSYNC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  input  logic i_enable,
  input  logic i_start,
  input  logic i_idle,
  output logic o_trigger,
  output logic o_vs_mode
);

  logic r_vsync_q;
  logic r_vs_mode;
  logic w_vs_rise;
  logic w_vs_trig;

  assign w_vs_rise = i_vsync & ~r_vsync_q;
  assign w_vs_trig = (AUTO_VSYNC != 0) & i_enable & w_vs_rise;
  assign o_trigger = i_idle & (i_start | w_vs_trig);
  assign o_vs_mode = r_vs_mode;

  // Delayed vsync for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vsync_q <= 1'b0;
    else       r_vsync_q <= i_vsync;
  end

  // Remember trigger source; start wins when both arrive together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_vs_mode <= 1'b0;
    else if (o_trigger) r_vs_mode <= ~i_start;
  end

endmodule

// File: rtl/vblank_dma.sv
// Bus-master block copy engine. Copies len bytes from src to dst, one
// read/write pair per two cycles while granted, triggered by software
// start or by a vsync rising edge.
module vblank_dma
  import vblank_dma_pkg::*;
#(
  parameter int LEN_W      = 11,
  parameter int AUTO_VSYNC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vsync,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic [15:0]      i_src,
  input  logic [15:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_gnt,
  input  logic [7:0]       i_din,
  output logic             o_req,
  output logic [15:0]      o_addr,
  output logic [7:0]       o_data,
  output logic             o_rw,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun
);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_src, w_src_nxt;
  logic [15:0]      r_dst, w_dst_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [15:0]      r_addr, w_addr_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_req, w_req_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             r_abort_pend, w_abort_pend_nxt;

  logic w_idle;
  logic w_trigger;
  logic w_vs_mode;
  logic w_abort_now;
  logic w_abort;

  assign w_idle = (r_state == ST_IDLE);

  vblank_dma_trigger #(
    .AUTO_VSYNC (AUTO_VSYNC)
  ) u_trigger (
    .clk       (clk),
    .reset     (reset),
    .i_vsync   (i_vsync),
    .i_enable  (i_enable),
    .i_start   (i_start),
    .i_idle    (w_idle),
    .o_trigger (w_trigger),
    .o_vs_mode (w_vs_mode)
  );

  // A vsync low seen during RD is remembered so the following WR still exits.
  assign w_abort_now = w_vs_mode & ~i_vsync;
  assign w_abort     = w_abort_now | r_abort_pend;

  // State and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_rem        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rw         <= RW_READ;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_src        <= w_src_nxt;
      r_dst        <= w_dst_nxt;
      r_rem        <= w_rem_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_rw         <= w_rw_nxt;
      r_req        <= w_req_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_overrun    <= w_overrun_nxt;
      r_abort_pend <= w_abort_pend_nxt;
    end
  end

  // Copy sequencing: next state and next register values.
  always_comb begin
    w_state_nxt      = r_state;
    w_src_nxt        = r_src;
    w_dst_nxt        = r_dst;
    w_rem_nxt        = r_rem;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_rw_nxt         = r_rw;
    w_req_nxt        = r_req;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_overrun_nxt    = r_overrun;
    w_abort_pend_nxt = r_abort_pend;

    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_src_nxt        = i_src;
          w_dst_nxt        = i_dst;
          w_rem_nxt        = i_len;
          w_overrun_nxt    = 1'b0;
          w_abort_pend_nxt = 1'b0;
          if (i_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_busy_nxt  = 1'b1;
            w_req_nxt   = 1'b1;
            w_rw_nxt    = RW_READ;
            w_state_nxt = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        w_rw_nxt = RW_READ;
        if (w_abort) begin
          w_req_nxt     = 1'b0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_overrun_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (i_gnt) begin
          w_addr_nxt  = r_src;
          w_state_nxt = ST_RD;
        end
      end

      ST_RD: begin
        if (w_abort_now) w_abort_pend_nxt = 1'b1;
        if (!i_gnt) begin
          w_rw_nxt    = RW_READ;
          w_state_nxt = ST_REQ;
        end else begin
          w_data_nxt  = i_din;
          w_addr_nxt  = r_dst;
          w_rw_nxt    = RW_WRITE;
          w_state_nxt = ST_WR;
        end
      end

      ST_WR: begin
        w_src_nxt = r_src + 16'd1;
        w_dst_nxt = r_dst + 16'd1;
        w_rem_nxt = r_rem - LEN_W'(1);
        w_rw_nxt  = RW_READ;
        if ((r_rem == LEN_W'(1)) || w_abort) begin
          w_req_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_rem != LEN_W'(1)) w_overrun_nxt = 1'b1;
        end else if (i_gnt) begin
          w_addr_nxt  = r_src + 16'd1;
          w_state_nxt = ST_RD;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_req     = r_req;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_rw      = r_rw;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_vblank_dma.sv
// Directed bench for vblank_dma: table of copy vectors plus hand-written
// sequences for grant loss, vsync abort, combined trigger and async reset.
module tb_vblank_dma;
  import vblank_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync, enable, start, gnt;
  logic [15:0] src, dst;
  logic [10:0] len;
  logic [7:0]  din;
  logic        req, rw, busy, done, overrun;
  logic [15:0] addr;
  logic [7:0]  data;

  logic [7:0]  mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  int          nwr;
  logic [15:0] wa [0:127];
  logic [7:0]  wd [0:127];
  logic        req_drop, busy_drop, end_busy, end_req, end_ovr;
  int          lat;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [10:0] len;
    int          exp_lat;
    int          exp_nwr;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] al;
    logic [7:0]  dl;
  } vec_t;

  vec_t vecs [0:4];

  vblank_dma #(.LEN_W(11), .AUTO_VSYNC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_vsync   (vsync),
    .i_enable  (enable),
    .i_start   (start),
    .i_src     (src),
    .i_dst     (dst),
    .i_len     (len),
    .i_gnt     (gnt),
    .i_din     (din),
    .o_req     (req),
    .o_addr    (addr),
    .o_data    (data),
    .o_rw      (rw),
    .o_busy    (busy),
    .o_done    (done),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  // Read-only source memory; writes are captured by the monitor in run_xfer.
  assign din = mem[addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode: 0 = start, 1 = vsync rise, 2 = both in the same cycle.
  // goff/glen: grant low for cycles goff..goff+glen-1 after acceptance.
  // vs_fall: vsync driven low from this cycle index onward.
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [10:0] l,
                          input int mode, input int goff, input int glen, input int vs_fall);
    @(negedge clk);
    src = s; dst = d; len = l;
    if (mode != 1) start = 1'b1;
    if (mode != 0) vsync = 1'b1;
    @(posedge clk);
    lat = -1; nwr = 0; req_drop = 1'b0; busy_drop = 1'b0;
    end_busy = 1'bx; end_req = 1'bx; end_ovr = 1'bx;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode != 0 && k >= vs_fall) vsync = 1'b0;
      gnt = !(k >= goff && k < goff + glen);
      if (rw === 1'b1 && nwr < 128) begin
        wa[nwr] = addr;
        wd[nwr] = data;
        nwr++;
      end
      if (done === 1'b1) begin
        lat = k; end_busy = busy; end_req = req; end_ovr = overrun;
        break;
      end
      if (req !== 1'b1)  req_drop  = 1'b1;
      if (busy !== 1'b1) busy_drop = 1'b1;
    end
    gnt = 1'b1;
    vsync = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2;
    mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'hD4;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'h66;

    vecs[0] = '{16'h0010, TB_BASE,    11'd4, 9, 4, 16'hF000, 8'hA1, 16'hF003, 8'hD4};
    vecs[1] = '{16'hFFFF, 16'hF3FF,   11'd2, 5, 2, 16'hF3FF, 8'h5A, 16'hF400, 8'h66};
    vecs[2] = '{16'h0010, SPR_BASE,   11'd1, 3, 1, 16'hEFF0, 8'hA1, 16'hEFF0, 8'hA1};
    vecs[3] = '{16'h0010, 16'hF000,   11'd0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[4] = '{16'h0012, 16'h0800,   11'd2, 5, 2, 16'h0800, 8'hC3, 16'h0801, 8'hD4};

    reset = 1'b1; vsync = 1'b0; enable = 1'b0; start = 1'b0; gnt = 1'b1;
    src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("rst_req",     {31'd0, req},     32'd0);
    chk("rst_rw",      {31'd0, rw},      32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_addr",    {16'd0, addr},    32'd0);
    chk("rst_data",    {24'd0, data},    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // vsync rise with enable low must not launch a transfer
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("noen_busy", {31'd0, busy}, 32'd0);
    chk("noen_req",  {31'd0, req},  32'd0);
    chk("noen_done", {31'd0, done}, 32'd0);
    vsync = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, 0, 1000, 0, 1000);
      chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_nwr", v), nwr, vecs[v].exp_nwr);
      if (vecs[v].exp_nwr > 0 && nwr > 0) begin
        chk($sformatf("v%0d_a0", v), {16'd0, wa[0]},     {16'd0, vecs[v].a0});
        chk($sformatf("v%0d_d0", v), {24'd0, wd[0]},     {24'd0, vecs[v].d0});
        chk($sformatf("v%0d_al", v), {16'd0, wa[nwr-1]}, {16'd0, vecs[v].al});
        chk($sformatf("v%0d_dl", v), {24'd0, wd[nwr-1]}, {24'd0, vecs[v].dl});
      end
      chk($sformatf("v%0d_reqhold", v),  {31'd0, req_drop},  32'd0);
      chk($sformatf("v%0d_busyhold", v), {31'd0, busy_drop}, 32'd0);
      chk($sformatf("v%0d_endbusy", v),  {31'd0, end_busy},  32'd0);
      chk($sformatf("v%0d_endreq", v),   {31'd0, end_req},   32'd0);
      chk($sformatf("v%0d_ovr", v),      {31'd0, end_ovr},   32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_donepulse", v), {31'd0, done}, 32'd0);
    end

    // grant lost for 3 cycles during the read of byte 2
    run_xfer(16'h0010, 16'hF100, 11'd4, 0, 3, 3, 1000);
    chk("gl_lat", lat, 13);
    chk("gl_nwr", nwr, 4);
    chk("gl_reqhold", {31'd0, req_drop}, 32'd0);
    for (int i = 0; i < 4 && i < nwr; i++) begin
      chk($sformatf("gl_a%0d", i), {16'd0, wa[i]}, 32'hF100 + i);
      chk($sformatf("gl_d%0d", i), {24'd0, wd[i]}, {24'd0, mem[16'h0010 + i]});
    end

    // vsync-launched transfer aborted when vsync falls
    run_xfer(16'h0010, 16'h0900, 11'd100, 1, 1000, 0, 9);
    chk("ab_seen",   {31'd0, lat >= 0}, 32'd1);
    chk("ab_nwrmax", {31'd0, nwr <= 6}, 32'd1);
    chk("ab_nwrmin", {31'd0, nwr >= 1}, 32'd1);
    chk("ab_ovr",    {31'd0, end_ovr},  32'd1);
    chk("ab_busy",   {31'd0, end_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ab_ovr_sticky", {31'd0, overrun}, 32'd1);
    run_xfer(16'h0010, 16'h0A00, 11'd1, 0, 1000, 0, 1000);
    chk("ab_ovr_clr", {31'd0, end_ovr}, 32'd0);
    chk("ab_next_lat", lat, 3);

    // start and vsync rise together: start-triggered, vsync fall ignored
    run_xfer(16'h0010, 16'h0A80, 11'd4, 2, 1000, 0, 2);
    chk("both_lat", lat, 9);
    chk("both_nwr", nwr, 4);
    chk("both_ovr", {31'd0, end_ovr}, 32'd0);
    @(negedge clk);

    // async reset in the middle of a write
    begin
      bit found;
      found = 1'b0;
      src = 16'h0010; dst = 16'h0B00; len = 11'd4; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (rw === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      start = 1'b0;
      chk("rs_reach_wr", {31'd0, found}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rs_rw",   {31'd0, rw},   32'd0);
      chk("rs_req",  {31'd0, req},  32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      chk("rs_addr", {16'd0, addr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end
    run_xfer(16'h0010, 16'hF200, 11'd4, 0, 1000, 0, 1000);
    chk("rs_fresh_lat", lat, 9);
    chk("rs_fresh_nwr", nwr, 4);
    if (nwr > 0) begin
      chk("rs_fresh_a0", {16'd0, wa[0]}, 32'hF200);
      chk("rs_fresh_d3", {24'd0, wd[nwr-1]}, 32'hD4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
